// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and the rotate-priority search used by the round-robin arbiter.
package mux_rr_arbiter_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Widest requester count the generic picker supports.
    localparam int PICK_IW = 5;
    localparam int MAX_N   = 1 << PICK_IW;

    typedef struct packed {
        logic               found;
        logic [PICK_IW-1:0] idx;
    } pick_t;

    // First set bit of req[n-1:0], searching upward from ptr and wrapping at n.
    // The caller keeps ptr < n and n <= MAX_N.
    function automatic pick_t rr_pick(input logic [MAX_N-1:0] req,
                                      input int               n,
                                      input int               ptr);
        pick_t r;
        int    j;
        r.found = 1'b0;
        r.idx   = '0;
        for (int k = 0; k < MAX_N; k++) begin
            j = ptr + k;
            if (j >= n) j = j - n;
            if (k < n && !r.found && req[j[PICK_IW-1:0]]) begin
                r.found = 1'b1;
                r.idx   = j[PICK_IW-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester-side and consumer-side valid/ready bundle of the arbiter.
interface mux_rr_arbiter_if #(
    parameter int N = 4,
    parameter int W = 8
);
    import mux_rr_arbiter_pkg::*;

    localparam int IW = $clog2(N);

    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic [IW-1:0]  out_id;
    logic           out_ready;

    // Arbiter side: accepts requester beats, presents the shared output.
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_id
    );

    // Environment side: producers plus the downstream consumer.
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_id
    );

endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational rotate-priority picker: one-hot grant plus its binary index.
module rr_pick_n
    import mux_rr_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    logic [MAX_N-1:0] req_ext;
    pick_t            pick;

    // Widen the request vector to the picker's fixed width, then search.
    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req_i;
        pick           = rr_pick(req_ext, N, int'(ptr_i));
    end

    assign idx_o   = pick.idx[IW-1:0];
    assign found_o = pick.found;

    for (genvar i = 0; i < N; i++) begin : g_gnt
        assign grant_o[i] = pick.found && (pick.idx == PICK_IW'(i));
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one registered output among N valid/ready
// requesters; multi-beat packets keep the grant until their last beat.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_rr_arbiter_if.slave  bus
);

    localparam int IW = $clog2(N);

    arb_state_t          state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       lock_id_q, lock_id_d;
    logic                out_valid_q;
    logic [W-1:0]        out_data_q;
    logic                out_last_q;
    logic [IW-1:0]       out_id_q;

    logic                load;
    logic                accept;
    logic [N-1:0]        lock_mask;
    logic [N-1:0]        elig;
    logic [IW-1:0]       pick_ptr;
    logic [N-1:0]        grant;
    logic [IW-1:0]       win_idx;
    logic                found;
    logic [N-1:0][W-1:0] data_arr;
    logic [W-1:0]        win_data;
    logic                win_last;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
        return (x == IW'(N - 1)) ? '0 : x + IW'(1);
    endfunction

    // The output register can take a beat when empty or being drained.
    assign load = !out_valid_q || bus.out_ready;

    for (genvar i = 0; i < N; i++) begin : g_lock
        assign lock_mask[i] = (lock_id_q == IW'(i));
    end

    // While locked only the owner is eligible; starting the search at the
    // owner makes the picker return it directly.
    assign elig     = (state_q == LOCK) ? (bus.in_valid & lock_mask) : bus.in_valid;
    assign pick_ptr = (state_q == LOCK) ? lock_id_q : ptr_q;

    rr_pick_n #(.N(N), .IW(IW)) u_pick (
        .req_i   (elig),
        .ptr_i   (pick_ptr),
        .grant_o (grant),
        .idx_o   (win_idx),
        .found_o (found)
    );

    // N:1 beat mux steered by the winner index.
    assign data_arr = bus.in_data;
    assign win_data = data_arr[win_idx];
    assign win_last = bus.in_last[win_idx];

    // Grant decode; held low during reset so no beat is taken before release.
    assign accept       = load && found;
    assign bus.in_ready = (rst_n && load) ? grant : '0;

    // Next-state: lock on a non-last beat, rotate priority past a finished packet.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        lock_id_d = lock_id_q;
        case (state_q)
            ARB: begin
                if (accept) begin
                    if (win_last) begin
                        ptr_d = wrap_inc(win_idx);
                    end else begin
                        state_d   = LOCK;
                        lock_id_d = win_idx;
                    end
                end
            end
            LOCK: begin
                if (accept && win_last) begin
                    state_d = ARB;
                    ptr_d   = wrap_inc(lock_id_q);
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Arbitration state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB;
            ptr_q     <= '0;
            lock_id_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            lock_id_q <= lock_id_d;
        end
    end

    // Output register: refill or empty on load, hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_id_q    <= '0;
        end else if (load) begin
            out_valid_q <= accept;
            if (accept) begin
                out_data_q <= win_data;
                out_last_q <= win_last;
                out_id_q   <= win_idx;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_id    = out_id_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (N=4, W=8): vector table plus reset sequences.
module tb_mux_rr_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_rr_arbiter_if #(.N(N), .W(W)) bus ();

    mux_rr_arbiter #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic [31:0] dat;    // {req3, req2, req1, req0}
        logic        ordy;
        logic [3:0]  e_rdy;
        logic        e_ov;
        logic [1:0]  e_id;
        logic [7:0]  e_dat;
        logic        e_last;
    } vec_t;

    vec_t tv[20];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                         input logic r);
        bus.in_valid  = v;
        bus.in_last   = l;
        bus.in_data   = d;
        bus.out_ready = r;
    endtask

    task automatic chk_out(input string tag, input logic [1:0] id, input logic [7:0] d,
                           input logic l);
        chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, " out_id"},    32'(bus.out_id),    32'(id));
        chk({tag, " out_data"},  32'(bus.out_data),  32'(d));
        chk({tag, " out_last"},  32'(bus.out_last),  32'(l));
    endtask

    initial begin
        // Round robin, all four single-beat requesters.
        tv[0]  = '{4'hF, 4'hF, 32'hA3A2A1A0, 1'b1, 4'h1, 1'b1, 2'd0, 8'hA0, 1'b1};
        tv[1]  = '{4'hF, 4'hF, 32'hA3A2A1A0, 1'b1, 4'h2, 1'b1, 2'd1, 8'hA1, 1'b1};
        tv[2]  = '{4'hF, 4'hF, 32'hA3A2A1A0, 1'b1, 4'h4, 1'b1, 2'd2, 8'hA2, 1'b1};
        tv[3]  = '{4'hF, 4'hF, 32'hA3A2A1A0, 1'b1, 4'h8, 1'b1, 2'd3, 8'hA3, 1'b1};
        tv[4]  = '{4'hF, 4'hF, 32'hA3A2A1A0, 1'b1, 4'h1, 1'b1, 2'd0, 8'hA0, 1'b1};
        // req1 three-beat packet, req2 requesting throughout.
        tv[5]  = '{4'h6, 4'h4, 32'h00201100, 1'b1, 4'h2, 1'b1, 2'd1, 8'h11, 1'b0};
        tv[6]  = '{4'h6, 4'h4, 32'h00201200, 1'b1, 4'h2, 1'b1, 2'd1, 8'h12, 1'b0};
        tv[7]  = '{4'h6, 4'h6, 32'h00201300, 1'b1, 4'h2, 1'b1, 2'd1, 8'h13, 1'b1};
        tv[8]  = '{4'h6, 4'h6, 32'h00201400, 1'b1, 4'h4, 1'b1, 2'd2, 8'h20, 1'b1};
        // Backpressure: held beat stays, nothing accepted, then resume.
        tv[9]  = '{4'h2, 4'h2, 32'h00001400, 1'b0, 4'h0, 1'b1, 2'd2, 8'h20, 1'b1};
        tv[10] = '{4'h2, 4'h2, 32'h00001400, 1'b0, 4'h0, 1'b1, 2'd2, 8'h20, 1'b1};
        tv[11] = '{4'h2, 4'h2, 32'h00001400, 1'b0, 4'h0, 1'b1, 2'd2, 8'h20, 1'b1};
        tv[12] = '{4'h2, 4'h2, 32'h00001400, 1'b1, 4'h2, 1'b1, 2'd1, 8'h14, 1'b1};
        tv[13] = '{4'h0, 4'h0, 32'h00000000, 1'b1, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0};
        // req0 locks, goes idle for 2 cycles while req3 waits, then finishes.
        tv[14] = '{4'h1, 4'h0, 32'h00000001, 1'b1, 4'h1, 1'b1, 2'd0, 8'h01, 1'b0};
        tv[15] = '{4'h8, 4'h8, 32'h31000000, 1'b1, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0};
        tv[16] = '{4'h8, 4'h8, 32'h31000000, 1'b1, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0};
        tv[17] = '{4'h9, 4'h9, 32'h31000002, 1'b1, 4'h1, 1'b1, 2'd0, 8'h02, 1'b1};
        tv[18] = '{4'h8, 4'h8, 32'h31000000, 1'b1, 4'h8, 1'b1, 2'd3, 8'h31, 1'b1};
        tv[19] = '{4'h0, 4'h0, 32'h00000000, 1'b1, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0};

        // Reset: requesters active, everything must read zero.
        drive(4'hF, 4'hF, 32'hA3A2A1A0, 1'b1);
        #2;
        chk("rst in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst out_data",  32'(bus.out_data),  32'd0);
        chk("rst out_last",  32'(bus.out_last),  32'd0);
        chk("rst out_id",    32'(bus.out_id),    32'd0);
        drive(4'h0, 4'h0, 32'h0, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk("idle out_valid", 32'(bus.out_valid), 32'd0);
        end

        // Table: inputs settle, check grant, clock, check registered output.
        for (int i = 0; i < 20; i++) begin
            drive(tv[i].vld, tv[i].lst, tv[i].dat, tv[i].ordy);
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'(tv[i].e_rdy));
            @(posedge clk); #1;
            if (tv[i].e_ov) chk_out($sformatf("v%0d", i), tv[i].e_id, tv[i].e_dat, tv[i].e_last);
            else chk($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'd0);
        end

        // Move ptr to 2, then lock on req2 and reset mid-packet.
        drive(4'h2, 4'h2, 32'h00001500, 1'b1);
        @(posedge clk); #1;
        chk_out("r1", 2'd1, 8'h15, 1'b1);
        drive(4'h4, 4'h0, 32'h00210000, 1'b1);
        #1;
        chk("r2 in_ready", 32'(bus.in_ready), 32'h4);
        @(posedge clk); #1;
        chk_out("r2", 2'd2, 8'h21, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst out_data",  32'(bus.out_data),  32'd0);
        chk("arst out_id",    32'(bus.out_id),    32'd0);
        chk("arst in_ready",  32'(bus.in_ready),  32'd0);
        drive(4'h5, 4'h5, 32'h00250005, 1'b1);
        #1;
        chk("arst tie in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        // ptr back at 0: req0 beats req2 despite the earlier rotation.
        chk("post in_ready", 32'(bus.in_ready), 32'h1);
        @(posedge clk); #1;
        chk_out("post0", 2'd0, 8'h05, 1'b1);
        #1;
        chk("post1 in_ready", 32'(bus.in_ready), 32'h4);
        @(posedge clk); #1;
        chk_out("post1", 2'd2, 8'h25, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
